seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised, time-multiplexed BCD-to-7-segment driver for the elevator floor/status display.
//  Scans N_DIGITS common-anode digits, one at a time, with a programmable refresh rate.
//  New values are accepted through a load/update_done handshake and applied only at a frame
//  boundary, so a frame never mixes old and new digits. Leading-zero blanking is optional.
//  Sits between the elevator FSM (value source) and the board's seg/an pins.
// PARAMETERS
//  N_DIGITS      4      number of scanned digits (1..8)
//  REFRESH_DIV   50000  clk cycles each digit is lit (>=2)
//  ACTIVE_LOW    1      1: lit segment = 0 and enabled anode = 0; 0: both active-high
//  BLANK_LEAD    1      1: blank leading zeros (digit 0 is never blanked)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            asynchronous, active-high reset
//  bcd_in       in   4*N_DIGITS   digit codes; [3:0] = digit 0 (rightmost)
//  dp_in        in   N_DIGITS     decimal-point enables, bit k = digit k
//  load         in   1            1-cycle strobe: capture bcd_in/dp_in into the pending register
//  update_done  out  1            1-cycle pulse when pending data becomes the displayed data
//  seg          out  7            segments {g,f,e,d,c,b,a}; polarity per ACTIVE_LOW
//  dp           out  1            decimal point; polarity per ACTIVE_LOW
//  an           out  N_DIGITS     digit enables, one-hot when active; polarity per ACTIVE_LOW
// BEHAVIOUR
//  Reset (async assert, sync release): prescaler=0, digit index=0, pending_valid=0,
//   pending=0, shadow codes=4'hF (blank), shadow dp=0, update_done=0; seg, dp and an all inactive.
//  Prescaler counts 0..REFRESH_DIV-1. At the terminal count, index advances and wraps
//   N_DIGITS-1 -> 0. The wrap to 0 is the frame boundary.
//  Outputs are registered. seg/dp/an reflect the new index 1 cycle after the index changes.
//   At most one anode is active in any cycle.
//  Handshake:
//   - load=1 latches bcd_in/dp_in into pending and sets pending_valid.
//   - A load while pending_valid=1 overwrites pending (last value wins; no extra pulse).
//   - In the cycle the index wraps to 0 with pending_valid=1: shadow<=pending,
//     pending_valid<=0, update_done=1 in the next cycle.
//   - If load coincides with that wrap, the old pending is applied and the new load becomes pending.
//  Decode (code -> gfedcba, active-high form before polarity):
//   0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07  8:7F  9:6F
//   A:40 '-'  B:79 'E'  C:73 'P'  D:3E 'U'  E:5E 'd'  F:00 (blank)
//  Leading blank (BLANK_LEAD=1): digit k>0 is blanked (seg and dp off) when its code is 0 and
//   every higher digit is 0 or blanked. Digit 0 is always shown. Evaluated on shadow only.
//  dp follows shadow dp for the active digit, except on blanked digits.
//  Reset mid-frame: everything returns to the reset state at once; a pending load is discarded.
// TESTING
//  1 Reset: reset=1 for 3 cycles -> seg=7'h7F, dp=1, an=4'hF (ACTIVE_LOW=1); update_done=0.
//  2 Scan (REFRESH_DIV=4, N=4): after release, an cycles E,D,B,7 with each value held 4 cycles,
//    frame = 16 cycles; never two anodes low at once.
//  3 Load 16'h0123, dp_in=4'b0100 mid-frame -> no change until the wrap to 0;
//    update_done pulses once; digits show 3,2,1 and dp on digit 2; digit 3 blank.
//  4 Back-to-back loads 16'h1111 then 16'h2222 before the wrap -> single update_done;
//    display shows 2222.
//  5 Load coinciding with the wrap cycle -> old pending is shown this frame and the new value
//    the next frame; two update_done pulses, one frame apart.
//  6 Codes A-F and BLANK_LEAD=0 with 16'h0000 -> seg patterns match the table (inverted);
//    all four zeros are shown. Assert reset mid-frame -> outputs go inactive immediately.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with frame-synchronous value updates
module seg7_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LEAD  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  output logic                  update_done,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic pol = ACTIVE_LOW != 0;
  localparam logic [6:0] seg_lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h79, 7'h73, 7'h3E, 7'h5E, 7'h00
  };
  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pending, shadow;
  logic [N_DIGITS-1:0]   pending_dp, shadow_dp, blank, an_n;
  logic                  pending_valid, tc, wrap, zero_above, dp_n;
  logic [3:0]            code;
  logic [6:0]            seg_n;
  assign tc   = presc == PW'(REFRESH_DIV - 1);
  assign wrap = tc && idx == IW'(N_DIGITS - 1);
  // a digit is a leading zero when it and every digit above it hold code 0
  always_comb begin
    blank = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && shadow[4*k +: 4] == 4'h0;
      blank[k] = BLANK_LEAD != 0 && k > 0 && zero_above;
    end
  end
  assign code  = shadow[{idx, 2'b00} +: 4];
  assign seg_n = blank[idx] ? 7'h00 : seg_lut[code];
  assign dp_n  = !blank[idx] && shadow_dp[idx];
  assign an_n  = N_DIGITS'(1) << idx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc         <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow        <= '1;
      shadow_dp     <= '0;
      update_done   <= 1'b0;
      seg           <= {7{pol}};
      dp            <= pol;
      an            <= {N_DIGITS{pol}};
    end else begin
      presc         <= tc ? '0 : presc + 1'b1;
      idx           <= wrap ? '0 : tc ? idx + 1'b1 : idx;
      update_done   <= wrap && pending_valid;
      pending_valid <= load || (pending_valid && !wrap);
      if (wrap && pending_valid) begin
        shadow    <= pending;
        shadow_dp <= pending_dp;
      end
      if (load) begin
        pending    <= bcd_in;
        pending_dp <= dp_in;
      end
      seg <= seg_n ^ {7{pol}};
      dp  <= dp_n ^ pol;
      an  <= an_n ^ {N_DIGITS{pol}};
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized bench with a frame-level reference model, blanking on and off
module tb_seg7_scan_driver;
  localparam int N = 4, RD = 4, FR = N * RD;
  localparam logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h79, 7'h73, 7'h3E, 7'h5E, 7'h00
  };
  logic clk = 0, reset = 1, load = 0;
  logic [15:0] bcd_in = '0;
  logic [3:0] dp_in = '0;
  logic ud1, dp1, ud0, dp0;
  logic [6:0] seg1, seg0;
  logic [3:0] an1, an0;
  int checks = 0, errors = 0;
  int p, o_dig;
  bit live, m_pv, m_ud;
  logic [15:0] m_pend, m_sh, o_sh;
  logic [3:0] m_pdp, m_shdp, o_dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEAD(1)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .update_done(ud1), .seg(seg1), .dp(dp1), .an(an1));
  seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEAD(0)) dut0 (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .update_done(ud0), .seg(seg0), .dp(dp0), .an(an0));

  task automatic model_reset();
    p = 0; live = 0; m_pv = 0; m_ud = 0;
    m_pend = '0; m_pdp = '0; m_sh = 16'hFFFF; m_shdp = '0; o_sh = 16'hFFFF; o_dp = '0; o_dig = 0;
  endtask

  // displayed digit is a pure function of elapsed cycles; data swaps only on frame multiples
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else begin
      live = 1; o_dig = (p / RD) % N; o_sh = m_sh; o_dp = m_shdp;
      p++;
      m_ud = 0;
      if (p % FR == 0 && m_pv) begin m_sh = m_pend; m_shdp = m_pdp; m_pv = 0; m_ud = 1; end
      if (load) begin m_pend = bcd_in; m_pdp = dp_in; m_pv = 1; end
    end
    @(negedge clk);
  endtask

  task automatic to_phase(input int ph);
    for (int i = 0; i < FR && p % FR != ph; i++) tick();
  endtask

  function automatic logic [11:0] exp_out(input bit bl);
    logic [6:0] s;
    logic d;
    logic [3:0] a;
    bit blank;
    if (!live) return {7'h7F, 1'b1, 4'hF};
    blank = bl && o_dig > 0 && (o_sh >> (4 * o_dig)) == 16'h0;
    s = blank ? 7'h00 : lut[o_sh[4*o_dig +: 4]];
    d = !blank && o_dp[o_dig];
    a = 4'(1 << o_dig);
    return {~s, ~d, ~a};
  endfunction

  function automatic logic [25:0] got_vec();
    return {seg1, dp1, an1, ud1, seg0, dp0, an0, ud0};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {exp_out(1'b1), m_ud, exp_out(1'b0), m_ud};
  endfunction

  task automatic test_reset();
    reset = 1; load = 0;
    repeat (3) tick();
    checks++;
    if (got_vec() !== 26'({7'h7F, 1'b1, 4'hF, 1'b0, 7'h7F, 1'b1, 4'hF, 1'b0})) begin
      errors++; $display("FAIL reset got %h exp %h", got_vec(), exp_vec());
    end
    checks++;
    if (got_vec() !== exp_vec()) begin errors++; $display("FAIL reset_model got %h exp %h", got_vec(), exp_vec()); end
    reset = 0;
  endtask

  task automatic test_scan();
    for (int c = 0; c < 2 * FR; c++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL scan c%0d got %h exp %h", c, got_vec(), exp_vec()); end
      checks++;
      if ($countones(~an1) > 1 || $countones(~an0) > 1) begin
        errors++; $display("FAIL onehot c%0d got an %h/%h exp at most one low", c, an1, an0);
      end
    end
  endtask

  task automatic test_load();
    int pulses = 0;
    to_phase(6);
    bcd_in = 16'h0123; dp_in = 4'b0100; load = 1;
    for (int c = 0; c < 40; c++) begin
      tick(); load = 0;
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL load c%0d got %h exp %h", c, got_vec(), exp_vec()); end
      pulses += int'(ud1);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL load_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    to_phase(2);
    bcd_in = 16'h1111; load = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 0) bcd_in = 16'h2222; else load = 0;
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL b2b c%0d got %h exp %h", c, got_vec(), exp_vec()); end
      pulses += int'(ud1);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL b2b_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_wrap_load();
    int n = 0, first = -1, second = -1;
    to_phase(4);
    bcd_in = 16'($urandom); dp_in = 4'($urandom); load = 1;
    tick(); load = 0;
    to_phase(FR - 1);
    bcd_in = 16'($urandom); dp_in = 4'($urandom); load = 1;
    for (int c = 0; c < 3 * FR; c++) begin
      tick(); load = 0;
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL wrapload c%0d got %h exp %h", c, got_vec(), exp_vec()); end
      if (ud1) begin if (n == 0) first = c; else second = c; n++; end
    end
    checks++;
    if (n != 2 || second - first != FR) begin
      errors++; $display("FAIL wrapload_pulses got %0d pulses gap %0d exp 2 gap %0d", n, second - first, FR);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 160; c++) begin
      load = $urandom_range(0, 5) == 0; bcd_in = 16'($urandom); dp_in = 4'($urandom);
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL random c%0d got %h exp %h", c, got_vec(), exp_vec()); end
    end
    load = 0;
  endtask

  task automatic test_codes_reset();
    logic [15:0] vals [3] = '{16'hDCBA, 16'h0FE0, 16'h0000};
    int pulses = 0;
    for (int v = 0; v < 3; v++) begin
      to_phase(3);
      bcd_in = vals[v]; dp_in = 4'($urandom); load = 1;
      for (int c = 0; c < 2 * FR; c++) begin
        tick(); load = 0;
        checks++;
        if (got_vec() !== exp_vec()) begin errors++; $display("FAIL codes v%0d c%0d got %h exp %h", v, c, got_vec(), exp_vec()); end
      end
    end
    to_phase(5);
    bcd_in = 16'h9876; dp_in = 4'hF; load = 1;
    tick(); load = 0;
    tick();
    reset = 1;
    #1;
    checks++;
    if (got_vec() !== 26'({7'h7F, 1'b1, 4'hF, 1'b0, 7'h7F, 1'b1, 4'hF, 1'b0})) begin
      errors++; $display("FAIL midreset got %h exp %h", got_vec(), 26'({7'h7F, 1'b1, 4'hF, 1'b0, 7'h7F, 1'b1, 4'hF, 1'b0}));
    end
    repeat (2) tick();
    reset = 0;
    for (int c = 0; c < 2 * FR + 4; c++) begin
      tick();
      checks++;
      if (got_vec() !== exp_vec()) begin errors++; $display("FAIL postreset c%0d got %h exp %h", c, got_vec(), exp_vec()); end
      pulses += int'(ud1);
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL discard_pending got %0d pulses exp 0", pulses); end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_wrap_load();
    test_random();
    test_codes_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
